// File: rtl/regfile_pkg.sv
// Shared CPU constants used by the register file: bus widths, enable levels
// and the local two-state FSM encoding.
package regfile_pkg;

   localparam int unsigned RegBusW    = 16;
   localparam int unsigned RegAddrW   = 4;
   localparam int unsigned RegNum     = 16;
   localparam int unsigned RegNumLog2 = 4;

   localparam logic              WriteEnable = 1'b1;
   localparam logic              ReadEnable  = 1'b1;
   localparam logic [RegBusW-1:0] ZeroWord   = '0;

   // FSM encoding: clearing after reset, then normal operation
   localparam logic StInit = 1'b0;
   localparam logic StRun  = 1'b1;

endpackage

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports with
// write-through bypass, one synchronous write port, and a hardware clear
// sequence after reset that holds ready low until every entry is zero.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned REG_NUM = RegNum,
   parameter int unsigned DATA_W  = RegBusW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [RegNumLog2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  re1,
   input  logic [RegNumLog2-1:0] raddr1,
   output logic [DATA_W-1:0]     rdata1,
   input  logic                  re2,
   input  logic [RegNumLog2-1:0] raddr2,
   output logic [DATA_W-1:0]     rdata2,
   output logic                  ready
);

   logic                  state_q, state_d;
   logic [RegNumLog2-1:0] clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0]     regs_q [REG_NUM];

   // One read port: reset/INIT, disable and r0 all force zero before bypass
   function automatic logic [DATA_W-1:0] read_port(
      input logic                  in_rst,
      input logic                  in_state,
      input logic                  ren,
      input logic [RegNumLog2-1:0] raddr,
      input logic                  wen,
      input logic [RegNumLog2-1:0] wa,
      input logic [DATA_W-1:0]     wd,
      input logic [DATA_W-1:0]     stored
   );
      logic [DATA_W-1:0] val;
      val = '0;
      if (in_rst || (in_state == StInit)) begin
         val = '0;
      end else if (ren != ReadEnable) begin
         val = '0;
      end else if (raddr == '0) begin
         val = '0;
      end else if ((wen == WriteEnable) && (wa == raddr)) begin
         val = wd;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   // Clear sequencer: the pointer walks 1..REG_NUM-1, wraps to 0, and the
   // wrapped cycle is the hand-off into RUN (16th edge after reset release)
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == StInit) begin
         if (clr_ptr_q == '0) begin
            state_d = StRun;
         end else begin
            clr_ptr_d = clr_ptr_q + 1'b1;
         end
      end
   end

   // FSM and clear pointer state, asynchronously forced back to INIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StInit;
         clr_ptr_q <= RegNumLog2'(1);
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Storage: cleared entry by entry in INIT, written by write-back in RUN
   always_ff @(posedge clk) begin
      if (state_q == StInit) begin
         if (!rst && (clr_ptr_q != '0)) begin
            regs_q[clr_ptr_q] <= '0;
         end
      end else if ((we == WriteEnable) && (waddr != '0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   // Read muxes and ready flag
   always_comb begin
      rdata1 = read_port(rst, state_q, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
      rdata2 = read_port(rst, state_q, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
      ready  = !rst && (state_q == StRun);
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against a behavioural array model.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        we, re1, re2;
   logic [3:0]  waddr, raddr1, raddr2;
   logic [15:0] wdata, rdata1, rdata2;
   logic        ready;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model: register contents and edges seen since reset release
   logic [15:0] mdl_mem [16];
   int          mdl_edges;

   regfile dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2),
      .ready  (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic mdl_ready();
      return (!rst) && (mdl_edges >= 16);
   endfunction

   function automatic logic [15:0] mdl_read(input logic re, input logic [3:0] a);
      if (!mdl_ready() || !re || a == 4'd0) return 16'h0000;
      if (we && waddr == a) return wdata;
      return mdl_mem[a];
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < 16; i++) mdl_mem[i] = 16'h0000;
      mdl_edges = 0;
   endtask

   // One cycle: drive at negedge, check combinational outputs, take the edge
   task automatic step(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                       input logic r1, input logic [3:0] a1,
                       input logic r2, input logic [3:0] a2);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
      #1;
      check("ready", {15'd0, ready}, {15'd0, mdl_ready()});
      check("rdata1", rdata1, mdl_read(re1, raddr1));
      check("rdata2", rdata2, mdl_read(re2, raddr2));
      @(posedge clk);
      if (mdl_ready() && we && waddr != 4'd0) mdl_mem[waddr] = wdata;
      if (mdl_edges < 16) mdl_edges++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   // One-cycle reset pulse starting at a negedge, with reads enabled on r4
   task automatic pulse_reset();
      re1 = 1'b1; raddr1 = 4'd4; re2 = 1'b1; raddr2 = 4'd4; we = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_ready", {15'd0, ready}, 16'h0000);
      check("rst_rdata1", rdata1, 16'h0000);
      check("rst_rdata2", rdata2, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      mdl_clear();
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
      mdl_clear();
      @(negedge clk);
      @(negedge clk);
      re1 = 1'b1; raddr1 = 4'd7;
      #1;
      check("reset_ready", {15'd0, ready}, 16'h0000);
      check("reset_rdata1", rdata1, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      re1 = 1'b0;

      // ready must stay low for 15 edges and be high from the 16th
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("ready_edge%0d", k), {15'd0, ready}, (k >= 16) ? 16'h1 : 16'h0);
      end
      @(negedge clk);
      mdl_edges = 16;

      // All entries read zero after the clear
      for (int a = 1; a < 16; a++) step(1'b0, 4'd0, 16'h0, 1'b1, 4'(a), 1'b1, 4'(16 - a));

      // Back-to-back writes then dual read
      step(1'b1, 4'd1, 16'h0008, 1'b0, 4'd0, 1'b0, 4'd0);
      step(1'b1, 4'd2, 16'h0010, 1'b0, 4'd0, 1'b0, 4'd0);
      we = 1'b0; re1 = 1'b1; raddr1 = 4'd1; re2 = 1'b1; raddr2 = 4'd2;
      #1;
      check("r1_read", rdata1, 16'h0008);
      check("r2_read", rdata2, 16'h0010);
      @(negedge clk);

      // Same-cycle bypass, then storage after the edge
      we = 1'b1; waddr = 4'd3; wdata = 16'h3443; re1 = 1'b1; raddr1 = 4'd3;
      #1;
      check("bypass_r3", rdata1, 16'h3443);
      step(1'b1, 4'd3, 16'h3443, 1'b1, 4'd3, 1'b1, 4'd3);
      we = 1'b0;
      #1;
      check("stored_r3", rdata1, 16'h3443);
      @(negedge clk);

      // r0 beats bypass; disabled port reads zero
      we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; re1 = 1'b1; raddr1 = 4'd0; re2 = 1'b1; raddr2 = 4'd0;
      #1;
      check("r0_bypass1", rdata1, 16'h0000);
      check("r0_bypass2", rdata2, 16'h0000);
      step(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0);
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b1, 4'd0);
      we = 1'b0; re1 = 1'b0; raddr1 = 4'd1;
      #1;
      check("re1_off", rdata1, 16'h0000);
      @(negedge clk);

      // Write attempted during INIT is dropped
      step(1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 1'b0, 4'd0);
      pulse_reset();
      idle(2);
      step(1'b1, 4'd5, 16'h1234, 1'b1, 4'd5, 1'b0, 4'd0);
      idle(13);
      we = 1'b0; re1 = 1'b1; raddr1 = 4'd5;
      #1;
      check("init_wr_ready", {15'd0, ready}, 16'h0001);
      check("init_wr_r5", rdata1, 16'h0000);
      @(negedge clk);

      // Reset mid-operation wipes r4
      step(1'b1, 4'd4, 16'h0005, 1'b0, 4'd0, 1'b0, 4'd0);
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0, 4'd0);
      pulse_reset();
      idle(16);
      we = 1'b0; re1 = 1'b1; raddr1 = 4'd4;
      #1;
      check("mid_rst_r4", rdata1, 16'h0000);
      @(negedge clk);

      // Randomized traffic with rare resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset();
         end else begin
            step(1'($urandom_range(0, 2) != 0), 4'($urandom), 16'($urandom),
                 1'($urandom_range(0, 5) != 0), 4'($urandom),
                 1'($urandom_range(0, 5) != 0), 4'($urandom));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
